// File: rtl/ntt_basemul.sv
// Pointwise NTT-domain multiplier for Kyber (q = 3329): 128 degree-1 base
// multiplications, one per cycle through a two-stage pipeline, published at once.
module ntt_basemul #(
    parameter int Q      = 3329,
    parameter int W      = 16,
    parameter int NPAIRS = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [W-1:0] a   [0:255],
    input  logic [W-1:0] b   [0:255],
    output logic [W-1:0] out [0:255],
    output logic         valid,
    output logic         busy
);
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [1:0]  S_DONE = 2'd2;
    localparam logic [6:0]  LAST   = 7'(NPAIRS - 1);
    localparam logic [25:0] QW     = 26'(Q);
    localparam logic [40:0] BAR_M  = 41'((64'd1 << 26) / 64'(Q));

    // Barrett reduction, exact for any x below 2^26 with one final correction.
    function automatic logic [11:0] mod_q(input logic [25:0] x);
        logic [14:0] qh;
        logic [25:0] r;
        qh = 15'(({15'd0, x} * BAR_M) >> 26);
        r  = x - 26'({11'd0, qh} * QW);
        r  = (r >= QW) ? (r - QW) : r;
        return r[11:0];
    endfunction

    function automatic logic [11:0] zeta_g(input int k);
        int e;
        int acc;
        e = 1;
        for (int i = 0; i < 7; i++) begin
            e = e + (((k >> i) & 1) << (7 - i));
        end
        acc = 1;
        for (int j = 0; j < e; j++) begin
            acc = (acc * 17) % Q;
        end
        return 12'(acc);
    endfunction

    logic [11:0] g_tab [0:127];
    for (genvar gi = 0; gi < 128; gi++) begin : g_rom
        localparam logic [11:0] GV = zeta_g(gi);
        assign g_tab[gi] = GV;
    end

    logic [1:0]  state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        drain_q, drain_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [11:0] a_buf_q [0:255];
    logic [11:0] b_buf_q [0:255];
    logic [11:0] res_q   [0:255];
    logic [W-1:0] out_q  [0:255];
    logic        s1_v_q;
    logic [6:0]  s1_idx_q;
    logic [23:0] p00_q, p11_q, p01_q, p10_q;
    logic [11:0] g_q;

    logic        capture_s, issue_s, write_last_s;
    logic [11:0] a0_s, a1_s, b0_s, b1_s;
    logic [11:0] red11_s;
    logic [25:0] even_sum_s, odd_sum_s;

    assign capture_s    = (state_q == S_IDLE) && !busy_q && enable;
    assign issue_s      = (state_q == S_RUN) && !drain_q;
    assign write_last_s = s1_v_q && (s1_idx_q == LAST);

    assign a0_s = a_buf_q[{cnt_q, 1'b0}];
    assign a1_s = a_buf_q[{cnt_q, 1'b1}];
    assign b0_s = b_buf_q[{cnt_q, 1'b0}];
    assign b1_s = b_buf_q[{cnt_q, 1'b1}];

    // a1*b1 is reduced before the twiddle multiply so the sum stays under 2^25.
    assign red11_s    = mod_q({2'd0, p11_q});
    assign even_sum_s = {2'd0, p00_q} + 26'({14'd0, red11_s} * {14'd0, g_q});
    assign odd_sum_s  = {2'd0, p01_q} + {2'd0, p10_q};

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;

    // Control FSM next-state: issue pairs, drain the pipeline, then publish.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (capture_s) begin
                    state_d = S_RUN;
                    cnt_d   = 7'd0;
                    drain_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (issue_s) begin
                    if (cnt_q == LAST) begin
                        drain_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
                if (write_last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 7'd0;
            drain_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Operand buffers: reduced copies of the inputs taken at the capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                a_buf_q[i] <= 12'd0;
                b_buf_q[i] <= 12'd0;
            end
        end else if (capture_s) begin
            for (int i = 0; i < 256; i++) begin
                a_buf_q[i] <= mod_q(26'(a[i]));
                b_buf_q[i] <= mod_q(26'(b[i]));
            end
        end
    end

    // Stage 1: raw products and the twiddle for the issued pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_idx_q <= 7'd0;
            p00_q    <= 24'd0;
            p11_q    <= 24'd0;
            p01_q    <= 24'd0;
            p10_q    <= 24'd0;
            g_q      <= 12'd0;
        end else begin
            s1_v_q <= issue_s;
            if (issue_s) begin
                s1_idx_q <= cnt_q;
                p00_q    <= {12'd0, a0_s} * {12'd0, b0_s};
                p11_q    <= {12'd0, a1_s} * {12'd0, b1_s};
                p01_q    <= {12'd0, a0_s} * {12'd0, b1_s};
                p10_q    <= {12'd0, a1_s} * {12'd0, b0_s};
                g_q      <= g_tab[cnt_q];
            end
        end
    end

    // Stage 2: reduced results into the internal buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                res_q[i] <= 12'd0;
            end
        end else if (s1_v_q) begin
            res_q[{s1_idx_q, 1'b0}] <= mod_q(even_sum_s);
            res_q[{s1_idx_q, 1'b1}] <= mod_q(odd_sum_s);
        end
    end

    // Published result: whole buffer copied on the valid edge only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                out_q[i] <= '0;
            end
        end else if (state_q == S_DONE) begin
            for (int i = 0; i < 256; i++) begin
                out_q[i] <= W'(res_q[i]);
            end
        end
    end
endmodule

// File: tb/tb_ntt_basemul.sv
// Directed bench for ntt_basemul with a queue scoreboard fed by an independent
// mod-q model of the base multiplications.
module tb_ntt_basemul;
    localparam int Q = 3329;
    typedef logic [255:0][15:0] poly_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] a   [0:255];
    logic [15:0] b   [0:255];
    logic [15:0] out [0:255];
    logic        valid;
    logic        busy;

    int    checks = 0;
    int    errors = 0;
    poly_t exp_q[$];
    int    ta [256];
    int    tb [256];
    poly_t held;
    int    e1, e2, bh, vcount;

    ntt_basemul dut (
        .clk(clk), .rst(rst), .enable(enable),
        .a(a), .b(b), .out(out), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic poly_t pack_out();
        poly_t p;
        for (int i = 0; i < 256; i++) p[i] = out[i];
        return p;
    endfunction

    task automatic chk_poly(input string tag, input poly_t obs, input poly_t expv);
        int idx;
        idx = -1;
        for (int i = 255; i >= 0; i--) if (obs[i] !== expv[i]) idx = i;
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: first diff at out[%0d] observed %0d expected %0d",
                   tag, idx, obs[idx], expv[idx]);
        end
    endtask

    function automatic int modpow(input int base, input int e);
        int r, x, k;
        r = 1; x = base % Q; k = e;
        while (k > 0) begin
            if ((k & 1) == 1) r = (r * x) % Q;
            x = (x * x) % Q;
            k = k >> 1;
        end
        return r;
    endfunction

    function automatic int brv7(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 7; i++) r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

    function automatic poly_t model();
        poly_t p;
        for (int k = 0; k < 128; k++) begin
            int a0, a1, b0, b1, g;
            a0 = ta[2*k] % Q;   a1 = ta[2*k+1] % Q;
            b0 = tb[2*k] % Q;   b1 = tb[2*k+1] % Q;
            g  = modpow(17, 2 * brv7(k) + 1);
            p[2*k]   = 16'((a0 * b0 + ((a1 * b1) % Q) * g) % Q);
            p[2*k+1] = 16'((a0 * b1 + a1 * b0) % Q);
        end
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < 256; i++) begin
            a[i] = 16'(ta[i]);
            b[i] = 16'(tb[i]);
        end
    endtask

    task automatic set_const(input int va, input int vb);
        for (int i = 0; i < 256; i++) begin
            ta[i] = va;
            tb[i] = vb;
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < 256; i++) begin
            ta[i] = int'($urandom_range(0, 65535));
            tb[i] = int'($urandom_range(0, 65535));
        end
    endtask

    // Steps until valid; edges counts steps taken, busy_hi counts busy samples incl. the capture one.
    task automatic wait_valid(input string tag, output int edges, output int busy_hi);
        edges = 0;
        busy_hi = busy ? 1 : 0;
        while (valid !== 1'b1 && edges < 300) begin
            step();
            edges++;
            if (busy === 1'b1 && valid !== 1'b1) busy_hi++;
        end
        if (valid !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed no valid expected valid within 300 edges", tag);
        end
    endtask

    task automatic check_out(input string tag);
        poly_t expv;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed result expected empty scoreboard", tag);
        end else begin
            expv = exp_q.pop_front();
            chk_poly(tag, pack_out(), expv);
        end
    endtask

    task automatic run_one(input string tag);
        drive();
        exp_q.push_back(model());
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk({tag, "_busy_cap"}, int'(busy), 1);
        wait_valid(tag, e1, bh);
        chk({tag, "_latency"}, e1, 130);
        chk({tag, "_busy_cycles"}, bh, 130);
        check_out(tag);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        set_const(0, 0);
        drive();
        step();
        step();
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk_poly("rst_out", pack_out(), '0);
        rst = 1'b0;
        step();

        // Single coefficient product.
        set_const(0, 0);
        ta[0] = 1; tb[0] = 1;
        run_one("t1");
        chk("t1_out0", int'(out[0]), 1);
        held = pack_out();
        step();
        chk("t1_valid_drop", int'(valid), 0);
        step();
        chk_poly("t1_out_hold", pack_out(), held);

        // Twiddle factors g0 and g1.
        set_const(0, 0);
        ta[1] = 1; tb[1] = 1; ta[3] = 1; tb[3] = 1;
        run_one("t2");
        chk("t2_out0", int'(out[0]), 17);
        chk("t2_out2", int'(out[2]), 3312);
        step();

        // All coefficients at q-1.
        set_const(3328, 3328);
        run_one("t3");
        chk("t3_out0", int'(out[0]), 18);
        chk("t3_out1", int'(out[1]), 2);
        chk("t3_out2", int'(out[2]), 3313);
        chk("t3_out4", int'(out[4]), 2762);
        step();

        // Unreduced operand.
        set_const(0, 0);
        ta[0] = 3334; tb[0] = 2;
        run_one("t4");
        chk("t4_out0", int'(out[0]), 10);
        step();

        // Max 16-bit inputs everywhere.
        set_const(65535, 65535);
        run_one("t4b");
        step();

        // Enable held high, operands changed mid-run.
        set_random();
        drive();
        exp_q.push_back(model());
        enable = 1'b1;
        step();
        repeat (50) step();
        set_random();
        drive();
        exp_q.push_back(model());
        wait_valid("t5a", e1, bh);
        chk("t5_first_latency", 50 + e1, 130);
        check_out("t5a");
        step();
        chk("t5_valid_drop", int'(valid), 0);
        chk("t5_recapture_busy", int'(busy), 1);
        enable = 1'b0;
        wait_valid("t5b", e2, bh);
        chk("t5_valid_spacing", e2 + 1, 131);
        check_out("t5b");
        step();

        // Reset at E0+60 aborts the run.
        set_random();
        drive();
        enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (59) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", int'(valid), 0);
        chk("t6_busy", int'(busy), 0);
        chk_poly("t6_out_clear", pack_out(), '0);
        vcount = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (valid === 1'b1) vcount++;
        end
        chk("t6_no_valid", vcount, 0);
        set_random();
        run_one("t6r");
        step();

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
